// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - Command-FIFO front-end sequencing requests onto a single-port RAM
// Reads wait for the RAM's out_en strobe, bounded by a timeout that yields an error response.
module ram_access_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_TIMEOUT = 8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wr,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_ram_en,
    output logic              o_ram_wr_rd,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_data_in,
    input  logic [DATA_W-1:0] i_ram_data_out,
    input  logic              i_ram_out_en,
    output logic              o_busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
    localparam int CMD_W = 1 + ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR       = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_GAP   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CMD_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_head_wr;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    logic              r_ram_en;
    logic              r_ram_wr_rd;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data_in;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_ram_en_nxt;
    logic              w_ram_wr_rd_nxt;
    logic [ADDR_W-1:0] w_ram_addr_nxt;
    logic [DATA_W-1:0] w_ram_data_in_nxt;
    logic [TMO_W-1:0]  w_tmo_nxt;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;
    logic              w_rsp_err_nxt;

    // Ready depends only on the registered count, so a same-cycle pop never frees a slot early.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = i_req_valid & ~w_full;
    assign {w_head_wr, w_head_addr, w_head_data} = r_fifo[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= {i_req_wr, i_req_addr, i_req_wdata};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pop             = 1'b0;
        w_ram_en_nxt      = r_ram_en;
        w_ram_wr_rd_nxt   = r_ram_wr_rd;
        w_ram_addr_nxt    = r_ram_addr;
        w_ram_data_in_nxt = r_ram_data_in;
        w_tmo_nxt         = r_tmo;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        case (r_state)
            // WR chains straight into the next command so writes stream one per cycle.
            S_IDLE, S_WR: begin
                if (!w_empty) begin
                    w_pop             = 1'b1;
                    w_ram_en_nxt      = 1'b1;
                    w_ram_wr_rd_nxt   = w_head_wr;
                    w_ram_addr_nxt    = w_head_addr;
                    w_ram_data_in_nxt = w_head_data;
                    w_state_nxt       = w_head_wr ? S_WR : S_RD_ISSUE;
                end else begin
                    w_ram_en_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                w_ram_en_nxt = 1'b0;
                w_tmo_nxt    = '0;
                w_state_nxt  = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (i_ram_out_en) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = i_ram_data_out;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = S_RD_GAP;
                end else if (r_tmo == TMO_LAST) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = S_RD_GAP;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            S_RD_GAP: begin
                w_ram_en_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_ram_en_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state       <= S_IDLE;
            r_ram_en      <= 1'b0;
            r_ram_wr_rd   <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_data_in <= '0;
            r_tmo         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ram_en      <= w_ram_en_nxt;
            r_ram_wr_rd   <= w_ram_wr_rd_nxt;
            r_ram_addr    <= w_ram_addr_nxt;
            r_ram_data_in <= w_ram_data_in_nxt;
            r_tmo         <= w_tmo_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
        end
    end

    assign o_req_ready   = ~w_full;
    assign o_busy        = ~w_empty | (r_state != S_IDLE);
    assign o_ram_en      = r_ram_en;
    assign o_ram_wr_rd   = r_ram_wr_rd;
    assign o_ram_addr    = r_ram_addr;
    assign o_ram_data_in = r_ram_data_in;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - Self-checking bench for ram_access_ctrl
`timescale 1ns/1ps
module tb_ram_access_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, rsp_err, ram_en, ram_wr_rd, busy;
    logic [DW-1:0] rsp_rdata, ram_data_in;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_out = '0;
    logic          ram_out_en = 1'b0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .RD_TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr(req_wr),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_ram_en(ram_en), .o_ram_wr_rd(ram_wr_rd), .o_ram_addr(ram_addr),
        .o_ram_data_in(ram_data_in), .i_ram_data_out(ram_data_out),
        .i_ram_out_en(ram_out_en), .o_busy(busy)
    );

    // Single-port RAM: read data and out_en strobe one cycle after a sampled read.
    logic [DW-1:0] mem [1<<AW];
    bit tie = 1'b0;
    always @(posedge clk) begin
        if (ram_en && ram_wr_rd) mem[ram_addr] <= ram_data_in;
        if (ram_en && !ram_wr_rd) begin
            ram_data_out <= mem[ram_addr];
            ram_out_en   <= !tie;
        end else begin
            ram_out_en <= 1'b0;
        end
    end

    typedef struct packed {bit wr; logic [AW-1:0] addr; logic [DW-1:0] data;} cmd_t;
    typedef struct packed {logic [DW-1:0] data; bit err;} rsp_t;
    typedef struct {bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [DW-1:0] exp;} vec_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    logic [DW-1:0] model_mem [1<<AW];
    int n_cmp = 0, n_fail = 0, cyc = 0, n_acc = 0, n_ram = 0;
    int run = 0, max_run = 0, stalls = 0;
    int last_acc_cyc = 0, last_ram_cyc = 0, last_rsp_cyc = 0, last_rd_cyc = -100;
    bit prev_rd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event occurred=1 required=0 (cycle %0d)", name, cyc);
    endtask

    task automatic monitor();
        cmd_t c;
        rsp_t r;
        cyc++;
        if (ram_en === 1'b1) begin
            run++;
            if (run > max_run) max_run = run;
            if (prev_rd) check("rd_gap_spacing_ok", int'(cyc - last_rd_cyc >= 4), 1);
            if (cmd_q.size() == 0) fail_now("ram_cmd_unexpected");
            else begin
                c = cmd_q.pop_front();
                check("ram_wr_rd", ram_wr_rd, c.wr);
                check("ram_addr", ram_addr, c.addr);
                if (c.wr) check("ram_data_in", ram_data_in, c.data);
            end
            n_ram++;
            last_ram_cyc = cyc;
            prev_rd = !ram_wr_rd;
            if (!ram_wr_rd) last_rd_cyc = cyc;
        end else begin
            run = 0;
        end
        check("req_ready", req_ready, int'((n_acc - n_ram) < DEPTH));
        if (req_ready === 1'b0) stalls++;
        if ((n_acc - n_ram) > 0 || ram_en === 1'b1) check("busy_active", busy, 1);
        if (rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) fail_now("rsp_unexpected");
            else begin
                r = rsp_q.pop_front();
                check("rsp_rdata", rsp_rdata, r.data);
                check("rsp_err", rsp_err, r.err);
            end
            last_rsp_cyc = cyc;
        end
    endtask

    task automatic cycle(input bit v, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit use_tab, input logic [DW-1:0] ed, input bit ee, output bit acc);
        cmd_t c;
        rsp_t r;
        @(negedge clk);
        monitor();
        req_valid = v; req_wr = w; req_addr = a; req_wdata = d;
        acc = v && (req_ready === 1'b1) && (rstn === 1'b1);
        if (acc) begin
            c.wr = w; c.addr = a; c.data = d;
            cmd_q.push_back(c);
            n_acc++;
            last_acc_cyc = cyc;
            if (w) model_mem[a] = d;
            else begin
                if (use_tab) begin r.data = ed; r.err = ee; end
                else begin r.data = tie ? '0 : model_mem[a]; r.err = tie; end
                rsp_q.push_back(r);
            end
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, acc);
    endtask

    task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit use_tab, input logic [DW-1:0] ed, input bit ee);
        bit acc = 1'b0;
        for (int k = 0; k < 60 && !acc; k++) cycle(1'b1, w, a, d, use_tab, ed, ee, acc);
        if (!acc) fail_now("send_timeout");
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while ((cmd_q.size() != 0 || rsp_q.size() != 0 || busy !== 1'b0) && k < maxc) begin
            idle(1);
            k++;
        end
        if (k >= maxc) fail_now("drain_timeout");
        idle(1);
    endtask

    vec_t tab[12];

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, s0;
        logic [DW-1:0] saved;
        bit acc;
        tab[0]  = '{1'b1, 4'd0, 8'h11, 8'h00};
        tab[1]  = '{1'b1, 4'd1, 8'h22, 8'h00};
        tab[2]  = '{1'b1, 4'd2, 8'h33, 8'h00};
        tab[3]  = '{1'b1, 4'd3, 8'h44, 8'h00};
        tab[4]  = '{1'b0, 4'd0, 8'h00, 8'h11};
        tab[5]  = '{1'b0, 4'd1, 8'h00, 8'h22};
        tab[6]  = '{1'b0, 4'd2, 8'h00, 8'h33};
        tab[7]  = '{1'b0, 4'd3, 8'h00, 8'h44};
        tab[8]  = '{1'b1, 4'd5, 8'h3C, 8'h00};
        tab[9]  = '{1'b0, 4'd5, 8'h00, 8'h3C};
        tab[10] = '{1'b1, 4'd5, 8'hC3, 8'h00};
        tab[11] = '{1'b0, 4'd5, 8'h00, 8'hC3};
        for (int i = 0; i < (1<<AW); i++) begin mem[i] = '0; model_mem[i] = '0; end

        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_ram_addr", ram_addr, 0);
        rstn = 1'b1;
        idle(2);

        send(1'b1, 4'd3, 8'hA5, 1'b0, '0, 1'b0);
        idle(6);
        check("wr_latency", last_ram_cyc - last_acc_cyc, 2);
        send(1'b0, 4'd3, '0, 1'b1, 8'hA5, 1'b0);
        a0 = last_acc_cyc;
        drain(50);
        check("rd_latency", last_rsp_cyc - a0, 4);

        max_run = 0;
        for (int i = 0; i < 12; i++) begin
            send(tab[i].wr, tab[i].addr, tab[i].data, !tab[i].wr, tab[i].exp, 1'b0);
            if (i == 3) begin
                drain(50);
                check("b2b_write_run", max_run, 4);
            end
        end
        drain(100);

        s0 = stalls;
        for (int i = 0; i < 6; i++) send(1'b0, 4'(i), '0, 1'b0, '0, 1'b0);
        check("fifo_full_stall_seen", int'(stalls > s0), 1);
        drain(100);

        tie = 1'b1;
        send(1'b0, 4'd7, '0, 1'b1, 8'h00, 1'b1);
        a0 = last_acc_cyc;
        drain(100);
        check("timeout_latency", last_rsp_cyc - a0, 11);
        tie = 1'b0;
        send(1'b1, 4'd7, 8'h5A, 1'b0, '0, 1'b0);
        send(1'b0, 4'd7, '0, 1'b1, 8'h5A, 1'b0);
        drain(100);

        tie = 1'b1;
        saved = model_mem[2];
        send(1'b0, 4'd1, '0, 1'b0, '0, 1'b0);
        send(1'b1, 4'd2, 8'h77, 1'b0, '0, 1'b0);
        send(1'b0, 4'd2, '0, 1'b0, '0, 1'b0);
        idle(3);
        check("pre_reset_busy", busy, 1);
        rstn = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_ram_en", ram_en, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rsp_err", rsp_err, 0);
        check("arst_ram_data_in", ram_data_in, 0);
        cmd_q.delete();
        rsp_q.delete();
        n_acc = 0; n_ram = 0; prev_rd = 1'b0;
        model_mem[2] = saved;
        idle(2);
        rstn = 1'b1;
        tie = 1'b0;
        idle(20);
        send(1'b0, 4'd2, '0, 1'b0, '0, 1'b0);
        drain(50);

        for (int k = 0; k < 400; k++) begin
            cycle(($urandom % 100) < 60, 1'($urandom % 2), 4'($urandom), 8'($urandom),
                  1'b0, '0, 1'b0, acc);
        end
        drain(300);
        check("final_cmd_q_empty", cmd_q.size(), 0);
        check("final_rsp_q_empty", rsp_q.size(), 0);
        check("final_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
